conv3x3_kernel_8bit: RTL and testbench



---
 rtl/conv3x3_kernel_8bit.sv | 185 ++++++++++++++++++
 tb/tb_conv3x3_kernel_8bit.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_kernel_8bit.sv
// 3x3 signed-coefficient convolution on window taps from the window generator.
// Three-stage pipeline, shadow/active coefficient banks, border suppression.
//
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   frame_start       one-cycle pulse before the first pixel of a frame
//   din_valid         window taps valid this cycle
//   din0..din8        unsigned taps, row-major, din4 is the centre
//   coef_we           shadow bank write strobe
//   coef_addr         0..8 coefficient k0..k8, 9 shift, 10..15 ignored
//   coef_data         signed coefficient, or shift in bits [3:0]
//   dout, dout_valid  filtered pixel and its strobe
module conv3x3_kernel_8bit #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       frame_start,
    input  logic       din_valid,
    input  logic [7:0] din0,
    input  logic [7:0] din1,
    input  logic [7:0] din2,
    input  logic [7:0] din3,
    input  logic [7:0] din4,
    input  logic [7:0] din5,
    input  logic [7:0] din6,
    input  logic [7:0] din7,
    input  logic [7:0] din8,
    input  logic       coef_we,
    input  logic [3:0] coef_addr,
    input  logic [7:0] coef_data,
    output logic [7:0] dout,
    output logic       dout_valid
);

    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(2);
    localparam logic [RW-1:0] ROW_MIN  = RW'(2);

    logic [7:0]         taps [9];
    logic signed [7:0]  shadow_k [9];
    logic signed [7:0]  active_k [9];
    logic [3:0]         shadow_shift;
    logic [3:0]         active_shift;

    logic [CW-1:0]      col;
    logic [RW-1:0]      row;
    logic [CW-1:0]      eff_col;
    logic [RW-1:0]      eff_row;
    logic               win_ok;

    logic signed [16:0] prod [9];
    logic signed [16:0] s1_p [9];
    logic               s1_valid;
    logic [3:0]         s1_shift;

    logic signed [18:0] s2_row [3];
    logic               s2_valid;
    logic [3:0]         s2_shift;

    logic signed [20:0] total;
    logic signed [20:0] shifted;
    logic [7:0]         sat;

    always_comb begin
        taps[0] = din0;
        taps[1] = din1;
        taps[2] = din2;
        taps[3] = din3;
        taps[4] = din4;
        taps[5] = din5;
        taps[6] = din6;
        taps[7] = din7;
        taps[8] = din8;
    end

    // Commit reads the shadow before any same-cycle write lands,
    // so a write coincident with frame_start waits for the next frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 9; i++) begin
                shadow_k[i] <= (i == 4) ? 8'sd1 : 8'sd0;
                active_k[i] <= (i == 4) ? 8'sd1 : 8'sd0;
            end
            shadow_shift <= 4'd0;
            active_shift <= 4'd0;
        end else begin
            if (frame_start) begin
                for (int i = 0; i < 9; i++) begin
                    active_k[i] <= shadow_k[i];
                end
                active_shift <= shadow_shift;
            end
            if (coef_we) begin
                if (coef_addr <= 4'd8) begin
                    shadow_k[coef_addr] <= coef_data;
                end else if (coef_addr == 4'd9) begin
                    shadow_shift <= coef_data[3:0];
                end
            end
        end
    end

    // A pixel arriving with frame_start is position (0,0) of the new frame.
    assign eff_col = frame_start ? '0 : col;
    assign eff_row = frame_start ? '0 : row;
    assign win_ok  = din_valid && (eff_col >= COL_MIN)
                     && (eff_row >= ROW_MIN);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col <= '0;
            row <= '0;
        end else if (din_valid) begin
            if (eff_col == COL_LAST) begin
                col <= '0;
                row <= (eff_row == ROW_LAST) ? '0 : eff_row + 1'b1;
            end else begin
                col <= eff_col + 1'b1;
                row <= eff_row;
            end
        end else if (frame_start) begin
            col <= '0;
            row <= '0;
        end
    end

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            prod[i] = 17'($signed({1'b0, taps[i]})) * 17'(active_k[i]);
        end
    end

    always_comb begin
        total   = 21'(s2_row[0]) + 21'(s2_row[1]) + 21'(s2_row[2]);
        shifted = total >>> s2_shift;
        if (shifted < 21'sd0) begin
            sat = 8'd0;
        end else if (shifted > 21'sd255) begin
            sat = 8'd255;
        end else begin
            sat = shifted[7:0];
        end
    end

    // Shift travels with the data so a commit never splits a window.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 9; i++) begin
                s1_p[i] <= '0;
            end
            s1_valid <= 1'b0;
            s1_shift <= 4'd0;
            for (int r = 0; r < 3; r++) begin
                s2_row[r] <= '0;
            end
            s2_valid   <= 1'b0;
            s2_shift   <= 4'd0;
            dout       <= 8'd0;
            dout_valid <= 1'b0;
        end else begin
            for (int i = 0; i < 9; i++) begin
                s1_p[i] <= prod[i];
            end
            s1_valid <= win_ok;
            s1_shift <= active_shift;
            for (int r = 0; r < 3; r++) begin
                s2_row[r] <= 19'(s1_p[3*r]) + 19'(s1_p[3*r+1])
                             + 19'(s1_p[3*r+2]);
            end
            s2_valid   <= s1_valid;
            s2_shift   <= s1_shift;
            dout_valid <= s2_valid;
            if (s2_valid) begin
                dout <= sat;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_kernel_8bit.sv
// Directed bench for conv3x3_kernel_8bit with an 8x4 frame.
// Each test task drives its scenario and checks results inline.
module tb_conv3x3_kernel_8bit;

    logic       clk = 1'b0;
    logic       rstn;
    logic       frame_start;
    logic       din_valid;
    logic [7:0] din0, din1, din2, din3, din4, din5, din6, din7, din8;
    logic       coef_we;
    logic [3:0] coef_addr;
    logic [7:0] coef_data;
    logic [7:0] dout;
    logic       dout_valid;

    int errors = 0;
    int checks = 0;

    logic       obs_v [128];
    logic [7:0] obs_d [128];

    conv3x3_kernel_8bit #(.IMG_W(8), .IMG_H(4)) dut (
        .clk(clk), .rstn(rstn), .frame_start(frame_start),
        .din_valid(din_valid),
        .din0(din0), .din1(din1), .din2(din2),
        .din3(din3), .din4(din4), .din5(din5),
        .din6(din6), .din7(din7), .din8(din8),
        .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data),
        .dout(dout), .dout_valid(dout_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_taps(input logic [7:0] v);
        din0 = v; din1 = v; din2 = v;
        din3 = v; din4 = v; din5 = v;
        din6 = v; din7 = v; din8 = v;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        coef_we = 1'b1;
        coef_addr = a;
        coef_data = d;
        step();
        coef_we = 1'b0;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    // Drives n windows then drain idle cycles; obs[s] is sampled after
    // step s and reflects the window presented at step s-2.
    task automatic run_windows(input int n, input int drain,
                               input bit idx4);
        for (int s = 0; s < n + drain; s++) begin
            din_valid = (s < n);
            if (idx4) din4 = 8'(s);
            step();
            obs_v[s] = dout_valid;
            obs_d[s] = dout;
        end
        din_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        frame_start = 1'b0;
        din_valid = 1'b0;
        coef_we = 1'b0;
        coef_addr = 4'd0;
        coef_data = 8'd0;
        set_taps(8'd0);
        step();
        step();
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %0b expected 0", dout_valid);
        end
        checks++;
        if (dout !== 8'd0) begin
            errors++;
            $display("FAIL reset_dout: got %0d expected 0", dout);
        end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_identity_stream();
        int  pulses;
        int  w;
        bit  ev;
        set_taps(8'd99);
        pulse_fs();
        run_windows(32, 3, 1'b1);
        pulses = 0;
        for (int s = 0; s < 35; s++) begin
            w  = s - 2;
            ev = (w >= 18 && w <= 23) || (w >= 26 && w <= 31);
            checks++;
            if (obs_v[s] !== ev) begin
                errors++;
                $display("FAIL ident_valid[%0d]: got %0b expected %0b",
                         s, obs_v[s], ev);
            end
            if (ev) begin
                pulses++;
                checks++;
                if (obs_d[s] !== 8'(w)) begin
                    errors++;
                    $display("FAIL ident_dout[%0d]: got %0d expected %0d",
                             s, obs_d[s], w);
                end
            end
        end
        checks++;
        if (pulses != 12) begin
            errors++;
            $display("FAIL ident_count: got %0d expected 12", pulses);
        end
    endtask

    task automatic test_counter_wrap();
        int  w;
        int  f;
        bit  ev;
        set_taps(8'd7);
        pulse_fs();
        run_windows(64, 3, 1'b1);
        for (int s = 0; s < 67; s++) begin
            w  = s - 2;
            f  = (w >= 0) ? (w % 32) : -1;
            ev = (w < 64) && ((f >= 18 && f <= 23) ||
                              (f >= 26 && f <= 31));
            checks++;
            if (obs_v[s] !== ev) begin
                errors++;
                $display("FAIL wrap_valid[%0d]: got %0b expected %0b",
                         s, obs_v[s], ev);
            end
            if (ev) begin
                checks++;
                if (obs_d[s] !== 8'(w)) begin
                    errors++;
                    $display("FAIL wrap_dout[%0d]: got %0d expected %0d",
                             s, obs_d[s], w);
                end
            end
        end
    endtask

    task automatic test_box_blur();
        for (int i = 0; i < 9; i++) wr(4'(i), 8'd1);
        wr(4'd9, 8'd3);
        pulse_fs();
        set_taps(8'd200);
        run_windows(20, 3, 1'b0);
        checks++;
        if (obs_v[19] !== 1'b0) begin
            errors++;
            $display("FAIL box_early: got %0b expected 0", obs_v[19]);
        end
        checks++;
        if (obs_v[20] !== 1'b1 || obs_d[20] !== 8'd225) begin
            errors++;
            $display("FAIL box_first: got v=%0b d=%0d expected v=1 d=225",
                     obs_v[20], obs_d[20]);
        end
        checks++;
        if (obs_v[21] !== 1'b1 || obs_d[21] !== 8'd225) begin
            errors++;
            $display("FAIL box_second: got v=%0b d=%0d expected v=1 d=225",
                     obs_v[21], obs_d[21]);
        end
        checks++;
        if (obs_v[22] !== 1'b0 || obs_d[22] !== 8'd225) begin
            errors++;
            $display("FAIL box_hold: got v=%0b d=%0d expected v=0 d=225",
                     obs_v[22], obs_d[22]);
        end
    endtask

    task automatic test_saturation();
        wr(4'd9, 8'd0);
        pulse_fs();
        set_taps(8'd255);
        run_windows(20, 3, 1'b0);
        checks++;
        if (obs_v[20] !== 1'b1 || obs_d[20] !== 8'd255) begin
            errors++;
            $display("FAIL sat_high: got v=%0b d=%0d expected v=1 d=255",
                     obs_v[20], obs_d[20]);
        end
        wr(4'd0, 8'hFF); wr(4'd1, 8'h00); wr(4'd2, 8'h01);
        wr(4'd3, 8'hFE); wr(4'd4, 8'h00); wr(4'd5, 8'h02);
        wr(4'd6, 8'hFF); wr(4'd7, 8'h00); wr(4'd8, 8'h01);
        pulse_fs();
        set_taps(8'd0);
        din0 = 8'd255; din3 = 8'd255; din6 = 8'd255;
        run_windows(20, 3, 1'b0);
        checks++;
        if (obs_v[20] !== 1'b1 || obs_d[20] !== 8'd0) begin
            errors++;
            $display("FAIL sobel_neg: got v=%0b d=%0d expected v=1 d=0",
                     obs_v[20], obs_d[20]);
        end
        set_taps(8'd0);
        din2 = 8'd255; din5 = 8'd255; din8 = 8'd255;
        pulse_fs();
        run_windows(20, 3, 1'b0);
        checks++;
        if (obs_v[20] !== 1'b1 || obs_d[20] !== 8'd255) begin
            errors++;
            $display("FAIL sobel_pos: got v=%0b d=%0d expected v=1 d=255",
                     obs_v[20], obs_d[20]);
        end
    endtask

    task automatic test_shadow_commit();
        int  pulses;
        bit  ev;
        for (int i = 0; i < 9; i++) wr(4'(i), (i == 4) ? 8'd1 : 8'd0);
        pulse_fs();
        set_taps(8'd50);
        run_windows(20, 3, 1'b0);
        checks++;
        if (obs_v[20] !== 1'b1 || obs_d[20] !== 8'd50) begin
            errors++;
            $display("FAIL commit_base: got v=%0b d=%0d expected v=1 d=50",
                     obs_v[20], obs_d[20]);
        end
        wr(4'd4, 8'd2);
        run_windows(12, 3, 1'b0);
        pulses = 0;
        for (int s = 2; s < 15; s++) begin
            ev = (s - 2 <= 3) || (s - 2 >= 6 && s - 2 <= 11);
            if (ev && obs_v[s] === 1'b1) pulses++;
            if (obs_v[s] === 1'b1) begin
                checks++;
                if (obs_d[s] !== 8'd50) begin
                    errors++;
                    $display("FAIL commit_mid[%0d]: got %0d expected 50",
                             s, obs_d[s]);
                end
            end
        end
        checks++;
        if (pulses != 10) begin
            errors++;
            $display("FAIL commit_mid_count: got %0d expected 10", pulses);
        end
        pulse_fs();
        run_windows(20, 3, 1'b0);
        checks++;
        if (obs_v[20] !== 1'b1 || obs_d[20] !== 8'd100) begin
            errors++;
            $display("FAIL commit_new: got v=%0b d=%0d expected v=1 d=100",
                     obs_v[20], obs_d[20]);
        end
        frame_start = 1'b1;
        wr(4'd4, 8'd3);
        frame_start = 1'b0;
        run_windows(20, 3, 1'b0);
        checks++;
        if (obs_v[20] !== 1'b1 || obs_d[20] !== 8'd100) begin
            errors++;
            $display("FAIL commit_coinc: got v=%0b d=%0d expected v=1 d=100",
                     obs_v[20], obs_d[20]);
        end
        pulse_fs();
        run_windows(20, 3, 1'b0);
        checks++;
        if (obs_v[20] !== 1'b1 || obs_d[20] !== 8'd150) begin
            errors++;
            $display("FAIL commit_next: got v=%0b d=%0d expected v=1 d=150",
                     obs_v[20], obs_d[20]);
        end
    endtask

    task automatic test_reset_midstream();
        int pulses;
        pulse_fs();
        set_taps(8'd50);
        run_windows(20, 0, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (dout_valid !== 1'b0 || dout !== 8'd0) begin
            errors++;
            $display("FAIL rst_mid: got v=%0b d=%0d expected v=0 d=0",
                     dout_valid, dout);
        end
        step();
        step();
        rstn = 1'b1;
        for (int s = 0; s < 5; s++) begin
            step();
            checks++;
            if (dout_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_stale[%0d]: got %0b expected 0",
                         s, dout_valid);
            end
        end
        din4 = 8'd77;
        run_windows(20, 3, 1'b0);
        pulses = 0;
        for (int s = 0; s < 23; s++) if (obs_v[s] === 1'b1) pulses++;
        checks++;
        if (pulses != 2 || obs_v[20] !== 1'b1) begin
            errors++;
            $display("FAIL rst_counters: got pulses=%0d v20=%0b expected 2 1",
                     pulses, obs_v[20]);
        end
        checks++;
        if (obs_d[20] !== 8'd77) begin
            errors++;
            $display("FAIL rst_identity: got %0d expected 77", obs_d[20]);
        end
    endtask

    task automatic test_addr_decode();
        wr(4'd9, 8'hF1);
        wr(4'd13, 8'h7F);
        wr(4'd15, 8'h7F);
        wr(4'd4, 8'd4);
        pulse_fs();
        set_taps(8'd10);
        run_windows(20, 3, 1'b0);
        checks++;
        if (obs_v[20] !== 1'b1 || obs_d[20] !== 8'd20) begin
            errors++;
            $display("FAIL addr_decode: got v=%0b d=%0d expected v=1 d=20",
                     obs_v[20], obs_d[20]);
        end
    endtask

    initial begin
        test_reset();
        test_identity_stream();
        test_counter_wrap();
        test_box_blur();
        test_saturation();
        test_shadow_commit();
        test_reset_midstream();
        test_addr_decode();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
